vdc_host_if: RTL and testbench
==============================

# vdc_host_if

Parametrised host-bus interface for the HuC6270 video display controller: decodes 8-bit CPU accesses (status/address register, data LSB, data MSB) into 16-bit register writes, VRAM read/write transactions with auto-increment, and a read-to-clear interrupt status. It sits between the CPU bus pins and the VDC core. The core owns the timing and sprite registers, which this block forwards. VRAM traffic goes out on a simple req/ack port.

## Interface
Parameters:
- VRAM_AW, 16, VRAM word-address width; MAWR/MARR wrap modulo 2^VRAM_AW
- REG_AW, 5, register-select (AR) width

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- CS_n, RD_n, WR_n  in  1 each  host strobes, synchronous to clock
- A  in  2  0 = status/AR, 2 = data LSB, 3 = data MSB, 1 = unused (accesses ignored)
- DI  in  8  host write data
- DO  out  8  host read data
- BUSY_n  out  1  low while a VRAM transaction is pending
- IRQ_n  out  1  low while any enabled status flag is set
- evt  in  6  single-cycle event pulses: [0] collision, [1] overflow, [2] raster, [3] SATB DMA done, [4] VRAM DMA done, [5] vblank
- vram_req, vram_we  out  1  transaction request, write enable
- vram_addr  out  VRAM_AW  word address
- vram_wdata  out  16  write data
- vram_rdata  in  16  read data, valid with ack
- vram_ack  in  1  single-cycle completion
- reg_wr  out  1  one-cycle pulse: 16-bit register committed
- reg_sel  out  REG_AW  register index
- reg_data  out  16  committed value

## Operation
- Access detection: a write occurs on the first cycle with CS_n=0 and WR_n=0 after a cycle where that condition was false. A read end is detected the same way on the rise of (CS_n|RD_n). Each host access acts exactly once.
- Write A=0: AR <= DI[REG_AW-1:0].
- Write A=2: lo_latch <= DI. Nothing commits.
- Write A=3: commits {DI, lo_latch} to register AR.
  - reg_wr pulses with reg_sel=AR, reg_data={DI, lo_latch} for every AR.
  - AR=0x00: MAWR <= value.
  - AR=0x01: MARR <= value. Issue a VRAM read at the new MARR, then MARR += inc.
  - AR=0x02: issue a VRAM write of value at MAWR, then MAWR += inc.
  - AR=0x05: CR shadow <= value. CR[3:0] are the enables for status bits 0, 1, 2, 5. CR[12:11] select inc (0:1, 1:32, 2:64, 3:128).
  - AR=0x0F: DCR shadow <= value. DCR[1:0] are the enables for status bits 3, 4.
- Read data (DO): DO=0x00 unless CS_n=0 and RD_n=0.
  - A=0 returns {1'b0, ~BUSY_n, status[5:0]}.
  - A=2 returns VRR[7:0].
  - A=3 returns VRR[15:8].
- Read side effects:
  - End of a status read clears status[5:0].
  - End of an A=3 read with AR=0x02 issues a prefetch at MARR, then MARR += inc.
- status[i] sets on evt[i]. Set wins over a clear in the same cycle.
- IRQ_n = ~|(status[5:0] & enable).
- FSM:
  - IDLE: a write commit goes to WR_REQ; a read trigger goes to RD_REQ.
  - WR_REQ / RD_REQ: hold vram_req until vram_ack, then return to IDLE.
  - RD_REQ with ack: VRR <= vram_rdata.
- A VRAM-triggering commit or read while not IDLE is dropped entirely; the address is not incremented. The plain register forward (reg_wr) still occurs.

## Timing
- Reset values: DO=0, BUSY_n=1, IRQ_n=1, vram_req=0, vram_we=0, vram_addr=0, vram_wdata=0, reg_wr=0, reg_sel=0, reg_data=0. Internal AR, MAWR, MARR, VRR, CR, DCR, lo_latch and status are all 0.
- Commit cycle is T:
  - reg_wr is high in T+1.
  - vram_req, vram_addr and vram_we are asserted from T+1 and held stable until the ack cycle, inclusive.
  - BUSY_n goes low at T+1 and returns high the cycle after ack.
  - The address increment is visible at T+1.
- Zero-wait ack (ack in T+1) is legal; FSM is back in IDLE at T+2.
- vram_ack in IDLE is ignored.
- Reset mid-transaction drops vram_req immediately and discards any later ack.
- IRQ_n is registered, one cycle after the evt or enable change.

## Configuration
- VDC_INC_SEL_EN defined: the increment is selected by CR[12:11] as above.
- Not defined: inc is fixed at 1, CR[12:11] are stored but ignored, and the increment logic is a simple +1.

## Test plan
- Increment 1: write AR=0, MAWR=0x1234, AR=2, data 0xBEEF, with ack on the 3rd cycle. Expect vram_we=1, addr=0x1234, wdata=0xBEEF, BUSY_n low for 3 cycles; a second write then goes to 0x1235.
- Increment 64 (macro on): write CR with [12:11]=2, MAWR=0xFFF0, then two writes. Expect addresses 0xFFF0 and 0x0030 (wrap).
- Read prefetch: MARR=0x0100 with ack returning 0xA55A. Reading A=2 gives 0x5A and A=3 gives 0xA5; the A=3 read triggers a prefetch at 0x0101.
- Interrupt: CR=0x0008, pulse evt[5]. IRQ_n goes low one cycle later; the status read returns 0x20; IRQ_n goes high after the read ends. An evt[5] in the clear cycle keeps the bit set.
- Busy drop: a second VWR commit during a pending write gets no new request and MAWR does not advance. reg_wr still pulses.
- Reset: assert reset_n low while vram_req=1. All outputs reach reset values immediately, and a later ack causes no VRR update.

Source files
------------

// File: rtl/vdc_host_if.sv
// HuC6270 host-bus interface: CPU byte accesses -> 16-bit register commits, VRAM req/ack traffic, read-to-clear IRQ status.
// Build option VDC_INC_SEL_EN: VRAM address increment selected by CR[12:11]; when undefined the increment is a fixed +1.
module vdc_host_if #(
  parameter int VRAM_AW = 16,
  parameter int REG_AW  = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               CS_n,
  input  logic               RD_n,
  input  logic               WR_n,
  input  logic [1:0]         A,
  input  logic [7:0]         DI,
  output logic [7:0]         DO,
  output logic               BUSY_n,
  output logic               IRQ_n,
  input  logic [5:0]         evt,
  output logic               vram_req,
  output logic               vram_we,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [15:0]        vram_wdata,
  input  logic [15:0]        vram_rdata,
  input  logic               vram_ack,
  output logic               reg_wr,
  output logic [REG_AW-1:0]  reg_sel,
  output logic [15:0]        reg_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WR_REQ = 2'd1,
    S_RD_REQ = 2'd2
  } state_t;

  localparam logic [REG_AW-1:0] AR_MAWR = REG_AW'(5'h00);
  localparam logic [REG_AW-1:0] AR_MARR = REG_AW'(5'h01);
  localparam logic [REG_AW-1:0] AR_VWR  = REG_AW'(5'h02);
  localparam logic [REG_AW-1:0] AR_CR   = REG_AW'(5'h05);
  localparam logic [REG_AW-1:0] AR_DCR  = REG_AW'(5'h0F);

  state_t              r_state;
  logic                r_wr_act;
  logic                r_rd_act;
  logic [1:0]          r_rd_a;
  logic [REG_AW-1:0]   r_ar;
  logic [7:0]          r_lo;
  logic [VRAM_AW-1:0]  r_mawr;
  logic [VRAM_AW-1:0]  r_marr;
  logic [15:0]         r_vrr;
  logic [15:0]         r_cr;
  logic [15:0]         r_dcr;
  logic [5:0]          r_status;
  logic                r_irq_n;

  logic                w_wr_act;
  logic                w_rd_act;
  logic                w_wr_start;
  logic                w_rd_end;
  logic                w_commit;
  logic                w_idle;
  logic                w_vwr;
  logic                w_vrd;
  logic                w_pref;
  logic                w_stat_clr;
  logic [15:0]         w_value;
  logic [VRAM_AW-1:0]  w_value_a;
  logic [15:0]         w_cr_nxt;
  logic [15:0]         w_dcr_nxt;
  logic [5:0]          w_status_nxt;
  logic [5:0]          w_en_nxt;
  logic [VRAM_AW-1:0]  w_inc;
  logic                w_unused;

  // Each host access acts once: writes on the leading edge of the strobe, reads on the trailing edge.
  assign w_wr_act   = ~CS_n & ~WR_n;
  assign w_rd_act   = ~CS_n & ~RD_n;
  assign w_wr_start = w_wr_act & ~r_wr_act;
  assign w_rd_end   = r_rd_act & ~w_rd_act;

  assign w_commit   = w_wr_start && (A == 2'd3);
  assign w_value    = {DI, r_lo};
  assign w_value_a  = VRAM_AW'(w_value);
  assign w_idle     = (r_state == S_IDLE);
  assign w_vwr      = w_commit && (r_ar == AR_VWR) && w_idle;
  assign w_vrd      = w_commit && (r_ar == AR_MARR) && w_idle;
  assign w_pref     = w_rd_end && (r_rd_a == 2'd3) && (r_ar == AR_VWR) && w_idle && !w_wr_start;
  assign w_stat_clr = w_rd_end && (r_rd_a == 2'd0);

  assign w_cr_nxt     = (w_commit && (r_ar == AR_CR))  ? w_value : r_cr;
  assign w_dcr_nxt    = (w_commit && (r_ar == AR_DCR)) ? w_value : r_dcr;
  // A new event outranks the read-clear landing in the same cycle.
  assign w_status_nxt = (w_stat_clr ? 6'd0 : r_status) | evt;
  assign w_en_nxt     = {w_cr_nxt[3], w_dcr_nxt[1], w_dcr_nxt[0], w_cr_nxt[2], w_cr_nxt[1], w_cr_nxt[0]};

`ifdef VDC_INC_SEL_EN
  always_comb begin
    case (r_cr[12:11])
      2'd0:    w_inc = VRAM_AW'(1);
      2'd1:    w_inc = VRAM_AW'(32);
      2'd2:    w_inc = VRAM_AW'(64);
      default: w_inc = VRAM_AW'(128);
    endcase
  end
`else
  assign w_inc = VRAM_AW'(1);
`endif

  assign w_unused = ^{r_cr[15:4], r_dcr[15:2]};
  assign IRQ_n    = r_irq_n;

  always_comb begin
    DO = 8'h00;
    if (w_rd_act) begin
      case (A)
        2'd0:    DO = {1'b0, ~BUSY_n, r_status};
        2'd2:    DO = r_vrr[7:0];
        2'd3:    DO = r_vrr[15:8];
        default: DO = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_wr_act   <= 1'b0;
      r_rd_act   <= 1'b0;
      r_rd_a     <= 2'd0;
      r_ar       <= '0;
      r_lo       <= 8'h00;
      r_mawr     <= '0;
      r_marr     <= '0;
      r_vrr      <= 16'h0000;
      r_cr       <= 16'h0000;
      r_dcr      <= 16'h0000;
      r_status   <= 6'd0;
      r_irq_n    <= 1'b1;
      BUSY_n     <= 1'b1;
      vram_req   <= 1'b0;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= 16'h0000;
      reg_wr     <= 1'b0;
      reg_sel    <= '0;
      reg_data   <= 16'h0000;
    end else begin
      r_wr_act <= w_wr_act;
      r_rd_act <= w_rd_act;
      if (w_rd_act) r_rd_a <= A;
      r_status <= w_status_nxt;
      r_irq_n  <= ~|(w_status_nxt & w_en_nxt);
      r_cr     <= w_cr_nxt;
      r_dcr    <= w_dcr_nxt;
      reg_wr   <= w_commit;
      if (w_wr_start && (A == 2'd0)) r_ar <= DI[REG_AW-1:0];
      if (w_wr_start && (A == 2'd2)) r_lo <= DI;
      if (w_commit) begin
        reg_sel  <= r_ar;
        reg_data <= w_value;
      end
      if (w_commit && (r_ar == AR_MAWR)) r_mawr <= w_value_a;
      // A MARR load that cannot start its read keeps the loaded address un-incremented.
      if (w_commit && (r_ar == AR_MARR)) r_marr <= w_idle ? (w_value_a + w_inc) : w_value_a;
      if (w_pref) r_marr <= r_marr + w_inc;

      case (r_state)
        S_IDLE: begin
          if (w_vwr) begin
            r_state    <= S_WR_REQ;
            vram_req   <= 1'b1;
            vram_we    <= 1'b1;
            vram_addr  <= r_mawr;
            vram_wdata <= w_value;
            BUSY_n     <= 1'b0;
            r_mawr     <= r_mawr + w_inc;
          end else if (w_vrd) begin
            r_state   <= S_RD_REQ;
            vram_req  <= 1'b1;
            vram_we   <= 1'b0;
            vram_addr <= w_value_a;
            BUSY_n    <= 1'b0;
          end else if (w_pref) begin
            r_state   <= S_RD_REQ;
            vram_req  <= 1'b1;
            vram_we   <= 1'b0;
            vram_addr <= r_marr;
            BUSY_n    <= 1'b0;
          end
        end
        default: begin
          if (vram_ack) begin
            if (r_state == S_RD_REQ) r_vrr <= vram_rdata;
            r_state  <= S_IDLE;
            vram_req <= 1'b0;
            vram_we  <= 1'b0;
            BUSY_n   <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vdc_host_if.sv
// Self-checking bench for vdc_host_if: directed scenarios plus randomized register/VRAM traffic against a behavioural model.
module tb_vdc_host_if;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } txn_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        CS_n = 1'b1;
  logic        RD_n = 1'b1;
  logic        WR_n = 1'b1;
  logic [1:0]  A = 2'd0;
  logic [7:0]  DI = 8'h00;
  logic [5:0]  evt = 6'd0;
  logic [15:0] vram_rdata = 16'h0000;
  logic        vram_ack = 1'b0;
  logic [7:0]  DO;
  logic        BUSY_n;
  logic        IRQ_n;
  logic        vram_req;
  logic        vram_we;
  logic [15:0] vram_addr;
  logic [15:0] vram_wdata;
  logic        reg_wr;
  logic [4:0]  reg_sel;
  logic [15:0] reg_data;

  int checks = 0;
  int failures = 0;
  int ack_delay = 0;
  int ack_cnt = 0;
  bit auto_ack = 1'b1;
  txn_t cap_q[$];
  logic [15:0] mem [logic [15:0]];

  logic [4:0]  m_ar = 5'd0;
  logic [15:0] m_mawr = 16'h0;
  logic [15:0] m_marr = 16'h0;
  logic [15:0] m_vrr = 16'h0;
  logic [15:0] m_cr = 16'h0;

  vdc_host_if dut (
    .clock(clock), .reset_n(reset_n), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n),
    .A(A), .DI(DI), .DO(DO), .BUSY_n(BUSY_n), .IRQ_n(IRQ_n), .evt(evt),
    .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .vram_ack(vram_ack),
    .reg_wr(reg_wr), .reg_sel(reg_sel), .reg_data(reg_data)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[7:0], a[15:8]} ^ 16'h5AA5;
  endfunction

  function automatic logic [15:0] m_inc();
`ifdef VDC_INC_SEL_EN
    case (m_cr[12:11])
      2'd0:    return 16'd1;
      2'd1:    return 16'd32;
      2'd2:    return 16'd64;
      default: return 16'd128;
    endcase
`else
    return 16'd1;
`endif
  endfunction

  // One clock step, then act as the VRAM: ack after ack_delay waiting cycles.
  task automatic tick();
    @(posedge clock);
    #1;
    if (vram_ack) vram_ack = 1'b0;
    else if (vram_req && auto_ack) begin
      if (ack_cnt == ack_delay) begin
        cap_q.push_back({vram_we, vram_addr, vram_we ? vram_wdata : 16'h0000});
        vram_rdata = mem_rd(vram_addr);
        if (vram_we) mem[vram_addr] = vram_wdata;
        vram_ack = 1'b1;
        ack_cnt = 0;
      end else ack_cnt++;
    end
  endtask

  task automatic host_wr(input logic [1:0] a, input logic [7:0] d);
    tick(); CS_n = 1'b0; WR_n = 1'b0; A = a; DI = d;
    tick(); CS_n = 1'b1; WR_n = 1'b1;
  endtask

  task automatic host_rd(input logic [1:0] a, output logic [7:0] d);
    tick(); CS_n = 1'b0; RD_n = 1'b0; A = a;
    #1 d = DO;
    tick(); CS_n = 1'b1; RD_n = 1'b1;
    tick();
  endtask

  task automatic reg_write(input logic [4:0] ar, input logic [15:0] v);
    host_wr(2'd0, {3'b000, ar});
    host_wr(2'd2, v[7:0]);
    host_wr(2'd3, v[15:8]);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && BUSY_n !== 1'b1; i++) tick();
    if (BUSY_n !== 1'b1) begin
      checks++; failures++;
      $display("FAIL wait_idle: BUSY_n=%b required 1 within 50 cycles", BUSY_n);
    end
  endtask

  // Behavioural effect of a 16-bit commit; returns the VRAM transaction it should cause.
  task automatic model_commit(input logic [4:0] ar, input logic [15:0] v, input bit busy,
                              output bit has, output txn_t e);
    has = 1'b0; e = '0; m_ar = ar;
    case (ar)
      5'h00: m_mawr = v;
      5'h01: begin
        m_marr = v;
        if (!busy) begin has = 1'b1; e = {1'b0, v, 16'h0}; m_vrr = mem_rd(v); m_marr = v + m_inc(); end
      end
      5'h02: if (!busy) begin has = 1'b1; e = {1'b1, m_mawr, v}; m_mawr = m_mawr + m_inc(); end
      5'h05: m_cr = v;
      default: ;
    endcase
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({DO, BUSY_n, IRQ_n, vram_req, vram_we, vram_addr, vram_wdata, reg_wr, reg_sel, reg_data} !==
        {8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 5'h0, 16'h0}) begin
      failures++;
      $display("FAIL reset_outputs: DO=%h BUSY_n=%b IRQ_n=%b req=%b we=%b addr=%h wdata=%h reg_wr=%b sel=%h data=%h required all idle/zero",
               DO, BUSY_n, IRQ_n, vram_req, vram_we, vram_addr, vram_wdata, reg_wr, reg_sel, reg_data);
    end
    reset_n = 1'b1;
    begin
      logic [7:0] d;
      host_rd(2'd0, d);
      checks++;
      if (d !== 8'h00) begin failures++; $display("FAIL reset_status: got %h required 00", d); end
      host_rd(2'd3, d);
      checks++;
      if (d !== 8'h00) begin failures++; $display("FAIL reset_vrr: got %h required 00", d); end
    end
  endtask

  task automatic test_inc1();
    bit has; txn_t e, g; int n; bit stable;
    ack_delay = 2;
    reg_write(5'h00, 16'h1234); model_commit(5'h00, 16'h1234, 0, has, e);
    reg_write(5'h02, 16'hBEEF); model_commit(5'h02, 16'hBEEF, 0, has, e);
    checks++;
    if ({vram_req, vram_we, vram_addr, vram_wdata, BUSY_n} !== {1'b1, 1'b1, 16'h1234, 16'hBEEF, 1'b0}) begin
      failures++;
      $display("FAIL inc1_req: req=%b we=%b addr=%h wdata=%h BUSY_n=%b required 1 1 1234 beef 0",
               vram_req, vram_we, vram_addr, vram_wdata, BUSY_n);
    end
    checks++;
    if ({reg_wr, reg_sel, reg_data} !== {1'b1, 5'h02, 16'hBEEF}) begin
      failures++; $display("FAIL inc1_regwr: wr=%b sel=%h data=%h required 1 02 beef", reg_wr, reg_sel, reg_data);
    end
    n = 1; stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (BUSY_n !== 1'b0) break;
      n++;
      if (!(vram_req === 1'b1 && vram_we === 1'b1 && vram_addr === 16'h1234)) stable = 1'b0;
    end
    checks++;
    if (n != 3) begin failures++; $display("FAIL inc1_busy_len: got %0d cycles required 3", n); end
    checks++;
    if (!stable) begin failures++; $display("FAIL inc1_hold: stable=%b required 1", stable); end
    reg_write(5'h02, 16'h0042); model_commit(5'h02, 16'h0042, 0, has, e);
    wait_idle();
    for (int k = 0; k < 2; k++) begin
      e = (k == 0) ? {1'b1, 16'h1234, 16'hBEEF} : {1'b1, 16'h1235, 16'h0042};
      g = (cap_q.size() != 0) ? cap_q.pop_front() : '0;
      checks++;
      if (g !== e) begin failures++; $display("FAIL inc1_txn%0d: got %h required %h", k, g, e); end
    end
  endtask

  task automatic test_inc64();
    bit has; txn_t e, g; logic [15:0] exp2;
    ack_delay = 0;
    reg_write(5'h05, 16'h1000); model_commit(5'h05, 16'h1000, 0, has, e);
    reg_write(5'h00, 16'hFFF0); model_commit(5'h00, 16'hFFF0, 0, has, e);
    reg_write(5'h02, 16'h0001); model_commit(5'h02, 16'h0001, 0, has, e);
    wait_idle();
    reg_write(5'h02, 16'h0002); model_commit(5'h02, 16'h0002, 0, has, e);
    wait_idle();
`ifdef VDC_INC_SEL_EN
    exp2 = 16'h0030;
`else
    exp2 = 16'hFFF1;
`endif
    for (int k = 0; k < 2; k++) begin
      e = (k == 0) ? {1'b1, 16'hFFF0, 16'h0001} : {1'b1, exp2, 16'h0002};
      g = (cap_q.size() != 0) ? cap_q.pop_front() : '0;
      checks++;
      if (g !== e) begin failures++; $display("FAIL inc64_txn%0d: got %h required %h", k, g, e); end
    end
    reg_write(5'h05, 16'h0000); model_commit(5'h05, 16'h0000, 0, has, e);
  endtask

  task automatic test_prefetch();
    bit has; txn_t e, g; logic [7:0] d;
    ack_delay = 1;
    mem[16'h0100] = 16'hA55A;
    mem[16'h0101] = 16'h1357;
    reg_write(5'h01, 16'h0100); model_commit(5'h01, 16'h0100, 0, has, e);
    wait_idle();
    g = (cap_q.size() != 0) ? cap_q.pop_front() : '0;
    checks++;
    if (g !== {1'b0, 16'h0100, 16'h0}) begin failures++; $display("FAIL pref_marr_txn: got %h required %h", g, {1'b0, 16'h0100, 16'h0}); end
    host_wr(2'd0, 8'h02); m_ar = 5'h02;
    host_rd(2'd2, d);
    checks++;
    if (d !== 8'h5A) begin failures++; $display("FAIL pref_lsb: got %h required 5a", d); end
    host_rd(2'd3, d);
    checks++;
    if (d !== 8'hA5) begin failures++; $display("FAIL pref_msb: got %h required a5", d); end
    checks++;
    if ({vram_req, vram_we, vram_addr} !== {1'b1, 1'b0, 16'h0101}) begin
      failures++; $display("FAIL pref_req: req=%b we=%b addr=%h required 1 0 0101", vram_req, vram_we, vram_addr);
    end
    wait_idle();
    m_vrr = 16'h1357; m_marr = 16'h0101 + m_inc();
    if (cap_q.size() != 0) void'(cap_q.pop_front());
    host_rd(2'd2, d);
    checks++;
    if (d !== 8'h57) begin failures++; $display("FAIL pref_data: got %h required 57", d); end
  endtask

  task automatic test_irq();
    bit has; txn_t e; logic [7:0] d;
    reg_write(5'h05, 16'h0008); model_commit(5'h05, 16'h0008, 0, has, e);
    checks++;
    if (IRQ_n !== 1'b1) begin failures++; $display("FAIL irq_idle: got %b required 1", IRQ_n); end
    evt = 6'h20; tick(); evt = 6'h00;
    checks++;
    if (IRQ_n !== 1'b0) begin failures++; $display("FAIL irq_assert: got %b required 0", IRQ_n); end
    host_rd(2'd0, d);
    checks++;
    if (d !== 8'h20) begin failures++; $display("FAIL irq_status: got %h required 20", d); end
    checks++;
    if (IRQ_n !== 1'b1) begin failures++; $display("FAIL irq_cleared: got %b required 1", IRQ_n); end
    evt = 6'h20; tick(); evt = 6'h00; tick();
    tick(); CS_n = 1'b0; RD_n = 1'b0; A = 2'd0;
    tick(); CS_n = 1'b1; RD_n = 1'b1; evt = 6'h20;
    tick(); evt = 6'h00;
    checks++;
    if (IRQ_n !== 1'b0) begin failures++; $display("FAIL irq_set_wins: IRQ_n=%b required 0", IRQ_n); end
    host_rd(2'd0, d);
    checks++;
    if (d !== 8'h20) begin failures++; $display("FAIL irq_set_wins_status: got %h required 20", d); end
    evt = 6'h01; tick(); evt = 6'h00; tick();
    checks++;
    if (IRQ_n !== 1'b1) begin failures++; $display("FAIL irq_masked: got %b required 1", IRQ_n); end
    host_rd(2'd0, d);
    checks++;
    if (d !== 8'h01) begin failures++; $display("FAIL irq_masked_status: got %h required 01", d); end
    reg_write(5'h05, 16'h0000); model_commit(5'h05, 16'h0000, 0, has, e);
  endtask

  task automatic test_busy_drop();
    bit has; txn_t e, g;
    ack_delay = 6;
    reg_write(5'h00, 16'h0200); model_commit(5'h00, 16'h0200, 0, has, e);
    reg_write(5'h02, 16'h1111); model_commit(5'h02, 16'h1111, 0, has, e);
    host_wr(2'd2, 8'h22);
    host_wr(2'd3, 8'h22); model_commit(5'h02, 16'h2222, 1, has, e);
    checks++;
    if ({reg_wr, reg_sel, reg_data} !== {1'b1, 5'h02, 16'h2222}) begin
      failures++; $display("FAIL drop_regwr: wr=%b sel=%h data=%h required 1 02 2222", reg_wr, reg_sel, reg_data);
    end
    checks++;
    if ({vram_req, vram_addr, vram_wdata} !== {1'b1, 16'h0200, 16'h1111}) begin
      failures++; $display("FAIL drop_pending: req=%b addr=%h wdata=%h required 1 0200 1111", vram_req, vram_addr, vram_wdata);
    end
    wait_idle();
    g = (cap_q.size() != 0) ? cap_q.pop_front() : '0;
    checks++;
    if (g !== {1'b1, 16'h0200, 16'h1111}) begin failures++; $display("FAIL drop_txn: got %h required %h", g, {1'b1, 16'h0200, 16'h1111}); end
    checks++;
    if (cap_q.size() != 0) begin failures++; $display("FAIL drop_extra: got %0d extra txns required 0", cap_q.size()); end
    ack_delay = 0;
    reg_write(5'h02, 16'h3333); model_commit(5'h02, 16'h3333, 0, has, e);
    wait_idle();
    g = (cap_q.size() != 0) ? cap_q.pop_front() : '0;
    checks++;
    if (g !== {1'b1, 16'h0201, 16'h3333}) begin failures++; $display("FAIL drop_next_addr: got %h required %h", g, {1'b1, 16'h0201, 16'h3333}); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int op;
      logic [4:0] ar;
      logic [15:0] v;
      logic [7:0] d;
      bit has;
      txn_t e, g;
      op = $urandom_range(0, 4);
      v = 16'($urandom);
      ack_delay = $urandom_range(0, 3);
      has = 1'b0; e = '0;
      if (op == 3) begin
        host_rd(2'd2, d);
        checks++;
        if (d !== m_vrr[7:0]) begin failures++; $display("FAIL rnd_lsb[%0d]: got %h required %h", i, d, m_vrr[7:0]); end
        host_rd(2'd3, d);
        checks++;
        if (d !== m_vrr[15:8]) begin failures++; $display("FAIL rnd_msb[%0d]: got %h required %h", i, d, m_vrr[15:8]); end
        if (m_ar == 5'h02) begin
          has = 1'b1; e = {1'b0, m_marr, 16'h0};
          m_vrr = mem_rd(m_marr); m_marr = m_marr + m_inc();
        end
      end else begin
        ar = (op == 0) ? 5'h00 : (op == 1) ? 5'h02 : (op == 2) ? 5'h01 : 5'h05;
        if (ar == 5'h05) v = v & 16'h1800;
        reg_write(ar, v);
        checks++;
        if ({reg_wr, reg_sel, reg_data} !== {1'b1, ar, v}) begin
          failures++; $display("FAIL rnd_regwr[%0d]: wr=%b sel=%h data=%h required 1 %h %h", i, reg_wr, reg_sel, reg_data, ar, v);
        end
        model_commit(ar, v, 0, has, e);
      end
      wait_idle();
      if (has) begin
        g = (cap_q.size() != 0) ? cap_q.pop_front() : '0;
        checks++;
        if (g !== e) begin failures++; $display("FAIL rnd_txn[%0d]: got %h required %h", i, g, e); end
      end
      checks++;
      if (cap_q.size() != 0) begin
        failures++; $display("FAIL rnd_stray[%0d]: got %0d unexpected txns required 0", i, cap_q.size());
        cap_q.delete();
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    auto_ack = 1'b0;
    reg_write(5'h01, 16'h0300);
    checks++;
    if (vram_req !== 1'b1) begin failures++; $display("FAIL rst_pending: req=%b required 1", vram_req); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({DO, BUSY_n, IRQ_n, vram_req, vram_we, vram_addr, vram_wdata, reg_wr, reg_sel, reg_data} !==
        {8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 5'h0, 16'h0}) begin
      failures++;
      $display("FAIL rst_async: BUSY_n=%b IRQ_n=%b req=%b we=%b addr=%h wdata=%h reg_wr=%b sel=%h data=%h required idle/zero",
               BUSY_n, IRQ_n, vram_req, vram_we, vram_addr, vram_wdata, reg_wr, reg_sel, reg_data);
    end
    vram_rdata = 16'hDEAD; vram_ack = 1'b1;
    tick();
    reset_n = 1'b1;
    vram_rdata = 16'hBEAD; vram_ack = 1'b1;
    tick();
    checks++;
    if ({vram_req, BUSY_n} !== 2'b01) begin failures++; $display("FAIL rst_late_ack: req=%b BUSY_n=%b required 0 1", vram_req, BUSY_n); end
    host_rd(2'd2, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL rst_vrr_lsb: got %h required 00", d); end
    host_rd(2'd3, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL rst_vrr_msb: got %h required 00", d); end
  endtask

  initial begin
    test_reset();
    test_inc1();
    test_inc64();
    test_prefetch();
    test_irq();
    test_busy_drop();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

endmodule
